// File: rtl/itf_arb_pkg.sv
// Shared types and helpers for the itf arbitrating register slice.
// Optional parity storage is enabled by defining ITF_ARB_SLICE_PARITY_EN.
package itf_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int MAX_CH     = 16;
  localparam int CH_W_DEF   = 2;

  // Occupancy of the two-entry output buffer: nothing, main only, main + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } arb_state_e;

  // One buffered beat at the default bus widths.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
    logic [CH_W_DEF-1:0]   ch;
`ifdef ITF_ARB_SLICE_PARITY_EN
    logic                  par;
`endif
  } arb_beat_t;

  // Round-robin pick: one-hot grant to the first valid channel at or after
  // ptr, searching upward modulo num_ch. Bits at and above num_ch stay zero.
  function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0] valid,
                                                input logic [3:0]        ptr,
                                                input int                num_ch);
    logic [MAX_CH-1:0] grant;
    logic              found;
    int                idx;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      idx = (int'(ptr) + i) % num_ch;
      if (i < num_ch && !found && valid[idx[3:0]]) begin
        grant[idx[3:0]] = 1'b1;
        found           = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/itf_arb_rr.sv
// Round-robin arbiter for the itf arbitrating slice: holds the rotating
// priority pointer and produces a one-hot grant plus its encoded index.
module itf_arb_rr
  import itf_arb_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] valid,
  input  logic              enable,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  logic [CH_W-1:0]   ptr;
  logic [MAX_CH-1:0] valid_ext;
  logic [MAX_CH-1:0] pick;
  logic              unused_pick;

  // Widen the request vector, pick the winner and gate it with enable.
  always_comb begin
    valid_ext               = '0;
    valid_ext[NUM_CH-1:0]   = valid;
    pick                    = rr_pick(valid_ext, 4'(ptr), NUM_CH);
    grant                   = enable ? pick[NUM_CH-1:0] : '0;
  end

  // Upper pick bits are always zero; fold them away so nothing dangles.
  assign unused_pick = ^pick;

  // Encode the one-hot grant into a channel index.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) grant_idx = CH_W'(i);
    end
  end

  // Move priority to the channel just after the winner; hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/itf_arb_slice.sv
// N-channel arbitrating register slice for the itf bus: round-robin merge of
// requester channels into a registered master port with a main + skid buffer.
// Define ITF_ARB_SLICE_PARITY_EN to store per-beat parity and drive out_par.
module itf_arb_slice
  import itf_arb_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int ADDR_W = ADDR_W_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*ADDR_W-1:0] in_addr,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
`ifdef ITF_ARB_SLICE_PARITY_EN
  output logic                     out_par,
`endif
  output logic [CH_W-1:0]          out_ch
);

  // Buffer entry at this instance's widths.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   ch;
`ifdef ITF_ARB_SLICE_PARITY_EN
    logic              par;
`endif
  } beat_t;

  arb_state_e        state;
  arb_state_e        next_state;
  beat_t             main_q;
  beat_t             skid_q;
  beat_t             in_beat;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              enable;
  logic              accept;
  logic              drain;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;

  // Grants depend only on registered state, so in_ready never sees out_ready.
  assign enable = rst && (state != TWO);

  itf_arb_rr #(
    .NUM_CH (NUM_CH)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .valid     (in_valid),
    .enable    (enable),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign in_ready  = grant;
  assign accept    = |grant;
  assign out_valid = (state != EMPTY);
  assign drain     = out_valid && out_ready;

  // Select the granted channel's fields as the incoming beat.
  always_comb begin
    in_beat      = '0;
    in_beat.addr = in_addr[grant_idx*ADDR_W +: ADDR_W];
    in_beat.data = in_data[grant_idx*DATA_W +: DATA_W];
    in_beat.ch   = grant_idx;
`ifdef ITF_ARB_SLICE_PARITY_EN
    in_beat.par  = ^{in_beat.addr, in_beat.data};
`endif
  end

  // Next occupancy and which buffer entries load this cycle.
  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          next_state   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          next_state = TWO;
          load_skid  = 1'b1;
        end else if (drain) begin
          next_state = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          next_state     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // Occupancy register; reset drops any buffered beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= next_state;
  end

  // Main and skid entries; main drives the outputs and holds while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_beat;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_beat;
    end
  end

  assign out_addr = main_q.addr;
  assign out_data = main_q.data;
  assign out_ch   = main_q.ch;
`ifdef ITF_ARB_SLICE_PARITY_EN
  assign out_par  = main_q.par;
`endif

endmodule
